fpmul32_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for IEEE-754 single-precision multiply around one combinational mult24.

---
 rtl/fpmul32_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_fpmul32_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul32_seq_ctrl.sv
// FP32 multiplier sequencer: handshake in, MUL -> NORM -> RND -> OUT, one operation in flight,
// wrapped around a single combinational 24x24 significand multiplier.

module mult24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);
  assign p = {24'd0, a} * {24'd0, b};
endmodule

module fpmul32_seq_ctrl #(
  parameter int unsigned TAG_W = 4,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_MUL  = 3'd2,
    ST_NORM = 3'd3,
    ST_RND  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NORMAL  = 3'd0,
    CL_QNAN    = 3'd1,
    CL_INVALID = 3'd2,
    CL_INF     = 3'd3,
    CL_ZERO    = 3'd4
  } class_t;

  state_t                  state_r, state_s;
  logic                    in_ready_r, out_valid_r;
  logic [31:0]             a_r, b_r;
  logic [TAG_W-1:0]        tag_r;
  logic [7:0]              ea_s, eb_s;
  logic [22:0]             fa_s, fb_s;
  logic                    a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [47:0]             prod_s, prod_r;
  logic                    sign_r;
  logic signed [9:0]       eraw_s, eraw_r;
  class_t                  class_s, class_r;
  logic [22:0]             man_s, man_r;
  logic                    g_s, g_r, st_s, st_r;
  logic signed [9:0]       e_s, e_r;
  logic                    rnd_up_s;
  logic [23:0]             man_rnd_s;
  logic [22:0]             man_fin_s;
  logic signed [9:0]       e_fin_s;
  logic [31:0]             result_s;
  logic [3:0]              flags_s;
  logic [31:0]             out_result_r;
  logic [3:0]              out_flags_r;
  logic [TAG_W-1:0]        out_tag_r;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_flags  = out_flags_r;
  assign out_tag    = out_tag_r;

  // Operand field decode; exponent zero covers denormals, which flush to zero
  assign ea_s     = a_r[30:23];
  assign eb_s     = b_r[30:23];
  assign fa_s     = a_r[22:0];
  assign fb_s     = b_r[22:0];
  assign a_zero_s = (ea_s == 8'h00);
  assign b_zero_s = (eb_s == 8'h00);
  assign a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
  assign b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
  assign a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
  assign b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
  assign eraw_s   = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;

  mult24 u_mult24 (
    .a ({~a_zero_s, fa_s}),
    .b ({~b_zero_s, fb_s}),
    .p (prod_s)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: state_s = ST_IDLE;
      ST_IDLE: begin
        if (in_valid) state_s = ST_MUL;
        else          state_s = ST_IDLE;
      end
      ST_MUL:  state_s = ST_NORM;
      ST_NORM: state_s = ST_RND;
      ST_RND:  state_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_OUT;
      end
      default: state_s = ST_INIT;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_OUT);
    end
  end

  // Special-case classification in priority order
  always_comb begin
    if (a_nan_s || b_nan_s) begin
      class_s = CL_QNAN;
    end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      class_s = CL_INVALID;
    end else if (a_inf_s || b_inf_s) begin
      class_s = CL_INF;
    end else if (a_zero_s || b_zero_s) begin
      class_s = CL_ZERO;
    end else begin
      class_s = CL_NORMAL;
    end
  end

  // Normalise: leading one sits at bit 47 or 46 of the product
  always_comb begin
    if (prod_r[47]) begin
      man_s = prod_r[46:24];
      g_s   = prod_r[23];
      st_s  = |prod_r[22:0];
      e_s   = eraw_r + 10'sd1;
    end else begin
      man_s = prod_r[45:23];
      g_s   = prod_r[22];
      st_s  = |prod_r[21:0];
      e_s   = eraw_r;
    end
  end

  assign rnd_up_s  = g_r & (st_r | man_r[0]);
  assign man_rnd_s = {1'b0, man_r} + {23'd0, rnd_up_s};

  // Round-to-nearest-even carry handling
  always_comb begin
    if (man_rnd_s[23]) begin
      man_fin_s = 23'd0;
      e_fin_s   = e_r + 10'sd1;
    end else begin
      man_fin_s = man_rnd_s[22:0];
      e_fin_s   = e_r;
    end
  end

  // Result packing and flags {invalid, overflow, underflow, inexact}
  always_comb begin
    result_s = 32'd0;
    flags_s  = 4'b0000;
    case (class_r)
      CL_QNAN: begin
        result_s = QNAN;
        flags_s  = 4'b0000;
      end
      CL_INVALID: begin
        result_s = QNAN;
        flags_s  = 4'b1000;
      end
      CL_INF: begin
        result_s = {sign_r, 8'hFF, 23'd0};
        flags_s  = 4'b0000;
      end
      CL_ZERO: begin
        result_s = {sign_r, 31'd0};
        flags_s  = 4'b0000;
      end
      CL_NORMAL: begin
        if (e_fin_s >= 10'sd255) begin
          result_s = {sign_r, 8'hFF, 23'd0};
          flags_s  = 4'b0101;
        end else if (e_fin_s <= 10'sd0) begin
          result_s = {sign_r, 31'd0};
          flags_s  = 4'b0011;
        end else begin
          result_s = {sign_r, e_fin_s[7:0], man_fin_s};
          flags_s  = {3'b000, g_r | st_r};
        end
      end
      default: begin
        result_s = QNAN;
        flags_s  = 4'b1000;
      end
    endcase
  end

  // Datapath registers, each stage loaded only in its own state
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      tag_r        <= '0;
      prod_r       <= 48'd0;
      sign_r       <= 1'b0;
      eraw_r       <= 10'sd0;
      class_r      <= CL_ZERO;
      man_r        <= 23'd0;
      g_r          <= 1'b0;
      st_r         <= 1'b0;
      e_r          <= 10'sd0;
      out_result_r <= 32'd0;
      out_flags_r  <= 4'b0000;
      out_tag_r    <= '0;
    end else begin
      if ((state_r == ST_IDLE) && in_valid) begin
        a_r   <= in_a;
        b_r   <= in_b;
        tag_r <= in_tag;
      end
      if (state_r == ST_MUL) begin
        prod_r  <= prod_s;
        sign_r  <= a_r[31] ^ b_r[31];
        eraw_r  <= eraw_s;
        class_r <= class_s;
      end
      if (state_r == ST_NORM) begin
        man_r <= man_s;
        g_r   <= g_s;
        st_r  <= st_s;
        e_r   <= e_s;
      end
      if (state_r == ST_RND) begin
        out_result_r <= result_s;
        out_flags_r  <= flags_s;
        out_tag_r    <= tag_r;
      end
    end
  end

endmodule

// File: tb/tb_fpmul32_seq_ctrl.sv
// Self-checking bench for fpmul32_seq_ctrl: directed spec vectors plus randomized operands
// checked against an arithmetic reference model of IEEE-754 multiply with the block's rules.

module tb_fpmul32_seq_ctrl;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpmul32_seq_ctrl #(.TAG_W(TAG_W), .QNAN(32'h7FC00000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag)
  );

  // Reference: returns {flags, result}; works on exact integer products
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, msb, sh;
    logic s;
    bit an, bn, ai, bi, az, bz, inexact, up;
    longint unsigned ma, mb, prod, kept, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn) return {4'b0000, 32'h7FC00000};
    if ((ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'd0};
    if (az || bz) return {4'b0000, s, 31'd0};
    ma   = 64'd8388608 + 64'(a[22:0]);
    mb   = 64'd8388608 + 64'(b[22:0]);
    prod = ma * mb;
    msb  = 0;
    for (int i = 0; i < 64; i++) if (prod[i]) msb = i;
    // value = prod * 2^(ea+eb-254-46); leading one at msb gives the biased exponent below
    e    = ea + eb - 127 - 46 + msb;
    sh   = msb - 23;
    kept = prod >> sh;
    rem  = prod - (kept << sh);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && kept[0]);
    inexact = (rem != 64'd0);
    kept = kept + 64'(up);
    if (kept == 64'd16777216) begin
      kept = kept >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inexact, s, e[7:0], kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      2: e = 8'($urandom_range(1, 40));
      3: e = 8'($urandom_range(215, 254));
      default: e = 8'($urandom_range(90, 164));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One full operation: accept, latency, result, optional output stall, release
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                       input int stall, input bit use_exp, input logic [35:0] exp_in,
                       input string name);
    logic [35:0]      exp_v;
    logic [31:0]      held_res;
    logic [3:0]       held_flags;
    logic [TAG_W-1:0] held_tag;
    int lat, wait_n;
    bit busy_bad;
    exp_v = use_exp ? exp_in : ref_mul(a, b);
    out_ready = (stall == 0);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    wait_n = 0;
    while (in_ready !== 1'b1 && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept_timeout in_ready=%b required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = TAG_W'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL %s latency got=%0d required=4", name, lat);
    end
    checks++;
    if (busy_bad || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s in_ready_busy got=%b required=0 during op", name, in_ready);
    end
    checks++;
    if (out_result !== exp_v[31:0]) begin
      failures++;
      $display("FAIL %s result a=%h b=%h got=%h required=%h", name, a, b, out_result, exp_v[31:0]);
    end
    checks++;
    if (out_flags !== exp_v[35:32]) begin
      failures++;
      $display("FAIL %s flags a=%h b=%h got=%b required=%b", name, a, b, out_flags, exp_v[35:32]);
    end
    checks++;
    if (out_tag !== tag) begin
      failures++;
      $display("FAIL %s tag got=%h required=%h", name, out_tag, tag);
    end
    held_res = out_result; held_flags = out_flags; held_tag = out_tag;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held_res ||
          out_flags !== held_flags || out_tag !== held_tag) begin
        failures++;
        $display("FAIL %s stall_hold cyc=%0d valid=%b ready=%b res=%h flags=%b tag=%h required 1 0 %h %b %h",
                 name, i, out_valid, in_ready, out_result, out_flags, out_tag, held_res, held_flags, held_tag);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 ||
        out_flags !== 4'd0 || out_tag !== 4'd0) begin
      failures++;
      $display("FAIL reset_hold ready=%b valid=%b res=%h flags=%b tag=%h required all zero",
               in_ready, out_valid, out_result, out_flags, out_tag);
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_cycle in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    do_op(32'h40400000, 32'h40000000, 4'd3, 0, 1'b1, {4'b0000, 32'h40C00000}, "t1_basic");
    do_op(32'h3F800001, 32'h3F800001, 4'd5, 0, 1'b1, {4'b0001, 32'h3F800002}, "t2_inexact");
    do_op(32'h7F800000, 32'h00000000, 4'd6, 0, 1'b1, {4'b1000, 32'h7FC00000}, "t3_inf_zero");
    do_op(32'hFF800000, 32'h40000000, 4'd7, 0, 1'b1, {4'b0000, 32'hFF800000}, "t3_neg_inf");
    do_op(32'h7F000000, 32'h40000000, 4'd8, 0, 1'b1, {4'b0101, 32'h7F800000}, "t4_overflow");
    do_op(32'h00800000, 32'h3F000000, 4'd9, 0, 1'b1, {4'b0011, 32'h00000000}, "t4_underflow");
    do_op(32'h7FC12345, 32'h3F800000, 4'd10, 0, 1'b0, 36'd0, "nan_operand");
    do_op(32'h3F800001, 32'h3FC00000, 4'd11, 0, 1'b0, 36'd0, "tie_to_even");
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 4'd12, 0, 1'b0, 36'd0, "round_carry");
    do_op(32'h00400000, 32'h7F000000, 4'd13, 0, 1'b0, 36'd0, "denormal_flush");
  endtask

  task automatic test_stall();
    do_op(32'hC0A00000, 32'h40400000, 4'd14, 10, 1'b1, {4'b0000, 32'hC1700000}, "t5_stall");
  endtask

  task automatic test_reset_mid_op();
    bit saw_valid;
    out_ready = 1'b1;
    in_a = 32'h40400000; in_b = 32'h40400000; in_tag = 4'd15; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t6_pre_accept in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 ||
        out_flags !== 4'd0 || out_tag !== 4'd0) begin
      failures++;
      $display("FAIL t6_after_rst ready=%b valid=%b res=%h flags=%b tag=%h required all zero",
               in_ready, out_valid, out_result, out_flags, out_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t6_ready_two_cycles in_ready=%b required 1", in_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL t6_aborted_op out_valid seen=1 required never");
    end
    do_op(32'h40800000, 32'h3E800000, 4'd2, 0, 1'b1, {4'b0000, 32'h3F800000}, "t6_next_op");
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) do_op(rand_fp(), rand_fp(), TAG_W'(i), 0, 1'b0, 36'd0, "b2b");
    checks++;
    if (cyc - c0 != 20) begin
      failures++;
      $display("FAIL b2b_throughput cycles=%0d required=20", cyc - c0);
    end
  endtask

  task automatic test_random();
    int st;
    for (int i = 0; i < 80; i++) begin
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(rand_fp(), rand_fp(), TAG_W'($urandom), st, 1'b0, 36'd0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
